// File: rtl/uart_pkt_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkt_pkg
// Shared definitions for the UART packet receive path.
//   state_t           : packet sequencer states (HUNT, PAYLOAD, CSUM)
//   DEFAULT_SYNC_BYTE : packet start marker used unless overridden
//   ERR_CNT_MAX       : saturation value of the error counter
//   sat_inc()         : saturating increment for the error counter
// Related build macro: UART_PKT_CHECKSUM_EN (enables the CSUM state in the top).
// ----------------------------------------------------------------------------
package uart_pkt_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CSUM    = 2'd2
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ERR_CNT_MAX       = 8'hFF;

  // Holds at ERR_CNT_MAX instead of wrapping back to zero.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == ERR_CNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/uart_pkt_timeout.sv
// ----------------------------------------------------------------------------
// uart_pkt_timeout
// Inter-byte watchdog for the packet sequencer. Counts clk cycles while
// 'run' is high and raises 'expired' for one cycle when the count reaches
// TIMEOUT_CYCLES.
// Ports:
//   clk     in  system clock
//   reset   in  synchronous, active-high reset
//   run     in  count enable (sequencer is inside a packet)
//   clear   in  restart the count (a byte arrived); dominates expiry
//   expired out one-cycle pulse, count reached TIMEOUT_CYCLES
// ----------------------------------------------------------------------------
module uart_pkt_timeout
  import uart_pkt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // A clear in the expiry cycle suppresses the pulse, so a byte that lands
  // exactly on the deadline is still accepted.
  assign expired = run && !clear && (count_q == CNT_W'(TIMEOUT_CYCLES));

  // The counter restarts after expiry so the pulse cannot repeat while the
  // sequencer is leaving its packet states.
  always_comb begin
    count_d = count_q;
    if (!run || clear || expired) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_packet_ctrl.sv
// ----------------------------------------------------------------------------
// uart_rx_packet_ctrl
// Turns the UART receiver byte stream into fixed-length packets for the game
// logic: hunts for SYNC_BYTE, collects PAYLOAD_BYTES bytes, optionally checks
// an XOR checksum byte, then offers the packet on a valid/ready handshake.
// Timeout, checksum and overrun errors are pulsed and counted.
// Build macro UART_PKT_CHECKSUM_EN: when defined a checksum byte follows the
// payload and err_csum can fire; otherwise err_csum is held at 0.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   rx_done_tick   one-cycle strobe, rx_data holds a new byte
//   rx_data[7:0]   received byte
//   pkt_ready      consumer accepts the current packet
//   pkt_valid      packet available, held until accepted
//   pkt_data       payload, first received byte in [7:0]
//   err_csum       one-cycle pulse, checksum mismatch
//   err_timeout    one-cycle pulse, inter-byte timeout
//   err_overrun    one-cycle pulse, packet dropped because output was full
//   err_count[7:0] saturating count of all error pulses
// ----------------------------------------------------------------------------
module uart_rx_packet_ctrl
  import uart_pkt_pkg::*;
#(
  parameter int         PAYLOAD_BYTES  = 4,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_done_tick,
  input  logic [7:0]                 rx_data,
  input  logic                       pkt_ready,
  output logic                       pkt_valid,
  output logic [8*PAYLOAD_BYTES-1:0] pkt_data,
  output logic                       err_csum,
  output logic                       err_timeout,
  output logic                       err_overrun,
  output logic [7:0]                 err_count
);

  localparam int IDX_W  = $clog2(PAYLOAD_BYTES) + 1;
  localparam int DATA_W = 8 * PAYLOAD_BYTES;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          csum_q, csum_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic                pkt_valid_q, pkt_valid_d;
  logic [DATA_W-1:0]   pkt_data_q, pkt_data_d;
  logic                err_csum_q, err_csum_d;
  logic                err_timeout_q, err_timeout_d;
  logic                err_overrun_q, err_overrun_d;
  logic [7:0]          err_count_q, err_count_d;

  logic                complete;
  logic                timer_run;
  logic                timer_expired;

  // The watchdog only matters once a sync byte has been seen; every byte
  // restarts it.
  assign timer_run = (state_q != ST_HUNT);

  uart_pkt_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .run    (timer_run),
    .clear  (rx_done_tick),
    .expired(timer_expired)
  );

  // Sequencer next state, shadow/checksum update, output handshake and error
  // bookkeeping. 'complete' marks the cycle of the final byte's tick; the
  // packet lands in the output register on the following edge.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    csum_d        = csum_q;
    shadow_d      = shadow_q;
    pkt_valid_d   = pkt_valid_q;
    pkt_data_d    = pkt_data_q;
    err_csum_d    = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;
    err_count_d   = err_count_q;
    complete      = 1'b0;

    if (pkt_valid_q && pkt_ready) begin
      pkt_valid_d = 1'b0;
    end

    case (state_q)
      ST_HUNT: begin
        if (rx_done_tick && (rx_data == SYNC_BYTE)) begin
          state_d = ST_PAYLOAD;
          idx_d   = '0;
          csum_d  = '0;
        end
      end

      ST_PAYLOAD: begin
        if (rx_done_tick) begin
          for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (idx_q == IDX_W'(i)) begin
              shadow_d[i*8 +: 8] = rx_data;
            end
          end
          csum_d = csum_q ^ rx_data;
          if (idx_q == IDX_W'(PAYLOAD_BYTES - 1)) begin
`ifdef UART_PKT_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d  = ST_HUNT;
            complete = 1'b1;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (timer_expired) begin
          state_d       = ST_HUNT;
          err_timeout_d = 1'b1;
        end
      end

`ifdef UART_PKT_CHECKSUM_EN
      ST_CSUM: begin
        if (rx_done_tick) begin
          state_d = ST_HUNT;
          if (rx_data == csum_q) begin
            complete = 1'b1;
          end else begin
            err_csum_d = 1'b1;
          end
        end else if (timer_expired) begin
          state_d       = ST_HUNT;
          err_timeout_d = 1'b1;
        end
      end
`endif

      default: begin
        state_d = ST_HUNT;
      end
    endcase

    // shadow_d already holds the final payload byte when the packet ends
    // without a checksum byte. An acceptance in the completion cycle frees
    // the output register for the new packet.
    if (complete) begin
      if (!pkt_valid_q || pkt_ready) begin
        pkt_valid_d = 1'b1;
        pkt_data_d  = shadow_d;
      end else begin
        err_overrun_d = 1'b1;
      end
    end

    if (err_csum_d || err_timeout_d || err_overrun_d) begin
      err_count_d = sat_inc(err_count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_HUNT;
      idx_q         <= '0;
      csum_q        <= '0;
      shadow_q      <= '0;
      pkt_valid_q   <= 1'b0;
      pkt_data_q    <= '0;
      err_csum_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      csum_q        <= csum_d;
      shadow_q      <= shadow_d;
      pkt_valid_q   <= pkt_valid_d;
      pkt_data_q    <= pkt_data_d;
      err_csum_q    <= err_csum_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
      err_count_q   <= err_count_d;
    end
  end

  assign pkt_valid   = pkt_valid_q;
  assign pkt_data    = pkt_data_q;
  assign err_csum    = err_csum_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_packet_ctrl
// Scoreboard bench for uart_rx_packet_ctrl. Works with UART_PKT_CHECKSUM_EN
// defined or undefined; the reference model follows the same macro.
// ----------------------------------------------------------------------------
module tb_uart_rx_packet_ctrl;
  import uart_pkt_pkg::*;

  localparam int         P    = 4;
  localparam int         T    = 40;
  localparam logic [7:0] SYNC = 8'hA5;
`ifdef UART_PKT_CHECKSUM_EN
  localparam int CSUM_EN = 1;
`else
  localparam int CSUM_EN = 0;
`endif

  localparam logic [2:0] E_CSUM = 3'b100;
  localparam logic [2:0] E_TMO  = 3'b010;
  localparam logic [2:0] E_OVR  = 3'b001;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           rx_done_tick = 1'b0;
  logic [7:0]     rx_data = 8'h00;
  logic           pkt_ready = 1'b0;
  logic           pkt_valid;
  logic [8*P-1:0] pkt_data;
  logic           err_csum;
  logic           err_timeout;
  logic           err_overrun;
  logic [7:0]     err_count;

  always #5 clk = ~clk;

  uart_rx_packet_ctrl #(
    .PAYLOAD_BYTES (P),
    .SYNC_BYTE     (SYNC),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_done_tick(rx_done_tick),
    .rx_data     (rx_data),
    .pkt_ready   (pkt_ready),
    .pkt_valid   (pkt_valid),
    .pkt_data    (pkt_data),
    .err_csum    (err_csum),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun),
    .err_count   (err_count)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [8*P-1:0] exp_pkt_q[$];
  logic [2:0]     exp_err_q[$];

  // Reference model: a byte-stream parser built on a queue of bytes seen since
  // the last sync, an idle-cycle count, and a flag for "output holds a packet".
  bit         m_in_pkt = 1'b0;
  bit         m_valid  = 1'b0;
  logic [7:0] m_buf[$];
  int         m_since  = 0;
  int         m_err_count = 0;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic unexpected(input string name, input logic [127:0] actual);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: DUT output %0h with nothing expected", name, actual);
  endtask

  function automatic void model_error(input logic [2:0] code);
    exp_err_q.push_back(code);
    if (m_err_count < 255) m_err_count++;
  endfunction

  // One clock of the model, given the inputs presented during that clock.
  function automatic void model_step(input bit tick, input logic [7:0] data, input bit rdy);
    bit             accepted;
    bit             done;
    logic [7:0]     x;
    logic [8*P-1:0] pkt;
    accepted = m_valid && rdy;
    done     = 1'b0;
    x        = 8'h00;
    pkt      = '0;
    if (tick) m_since = 0;
    else      m_since++;
    // A byte is allowed up to T+1 cycles after the previous one.
    if (m_in_pkt && !tick && m_since == T + 1) begin
      m_in_pkt = 1'b0;
      model_error(E_TMO);
    end
    if (tick) begin
      if (!m_in_pkt) begin
        if (data == SYNC) begin
          m_in_pkt = 1'b1;
          m_buf.delete();
        end
      end else begin
        m_buf.push_back(data);
        if (m_buf.size() == P + CSUM_EN) begin
          m_in_pkt = 1'b0;
          for (int i = 0; i < P; i++) begin
            x = x ^ m_buf[i];
            pkt[i*8 +: 8] = m_buf[i];
          end
          if (CSUM_EN == 1 && m_buf[P] != x) model_error(E_CSUM);
          else                               done = 1'b1;
        end
      end
    end
    if (accepted) m_valid = 1'b0;
    if (done) begin
      if (!m_valid) begin
        exp_pkt_q.push_back(pkt);
        m_valid = 1'b1;
      end else begin
        model_error(E_OVR);
      end
    end
  endfunction

  task automatic applyStimulus(input bit tick, input logic [7:0] data, input bit rdy);
    rx_done_tick = tick;
    rx_data      = data;
    pkt_ready    = rdy;
    model_step(tick, data, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'($urandom), rdy);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit rdy);
    idle(gap, rdy);
    applyStimulus(1'b1, b, rdy);
  endtask

  task automatic send_packet(input logic [8*P-1:0] payload, input bit bad, input int gap,
                             input bit rdy, input bit rdy_last);
    logic [7:0] x;
    x = 8'h00;
    send_byte(SYNC, gap, rdy);
    for (int i = 0; i < P; i++) begin
      x = x ^ payload[i*8 +: 8];
      send_byte(payload[i*8 +: 8], gap, (CSUM_EN == 0 && i == P - 1) ? rdy_last : rdy);
    end
    if (CSUM_EN == 1) send_byte(bad ? ~x : x, gap, rdy_last);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    rx_done_tick = 1'b0;
    pkt_ready    = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset    = 1'b0;
    m_in_pkt = 1'b0;
    m_valid  = 1'b0;
    m_since  = 0;
    m_err_count = 0;
    m_buf.delete();
    exp_pkt_q.delete();
    exp_err_q.delete();
  endtask

  task automatic checkpoint(input string tag);
    idle(3, 1'b1);
    checkOutput({tag, "_err_count"}, err_count, m_err_count);
    checkOutput({tag, "_pkts_pending"}, exp_pkt_q.size(), 0);
    checkOutput({tag, "_errs_pending"}, exp_err_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_pkt_valid"}, pkt_valid, 0);
    checkOutput({tag, "_pkt_data"}, pkt_data, 0);
    checkOutput({tag, "_err_flags"}, {err_csum, err_timeout, err_overrun}, 0);
    checkOutput({tag, "_err_count"}, err_count, 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over a packet or
  // pulses an error, and checks the held packet does not change.
  logic [8*P-1:0] held_data;
  bit             holding = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      holding = 1'b0;
    end else begin
      if (holding && pkt_valid) checkOutput("pkt_data_stable", pkt_data, held_data);
      if (pkt_valid && pkt_ready) begin
        if (exp_pkt_q.size() == 0) unexpected("pkt_accept", pkt_data);
        else checkOutput("pkt_data", pkt_data, exp_pkt_q.pop_front());
      end
      holding   = pkt_valid && !pkt_ready;
      held_data = pkt_data;
      if (err_csum || err_timeout || err_overrun) begin
        if (exp_err_q.size() == 0) unexpected("err_pulse", {err_csum, err_timeout, err_overrun});
        else checkOutput("err_kind", {err_csum, err_timeout, err_overrun}, exp_err_q.pop_front());
      end
    end
  end

  initial begin
    int gap;
    bit rdy;
    do_reset();
    check_reset_outputs("reset");

    // Basic good packet, held with ready low, then accepted.
    send_packet(32'h44332211, 1'b0, 1, 1'b0, 1'b0);
    idle(2, 1'b0);
    checkOutput("t1_valid", pkt_valid, 1);
    checkOutput("t1_data", pkt_data, 32'h44332211);
    checkOutput("t1_no_err", err_count, 0);
    checkpoint("t1");

    // Bad checksum byte.
    if (CSUM_EN == 1) begin
      send_byte(SYNC, 0, 1'b1);
      send_byte(8'h11, 0, 1'b1);
      send_byte(8'h22, 0, 1'b1);
      send_byte(8'h33, 0, 1'b1);
      send_byte(8'h44, 0, 1'b1);
      send_byte(8'h00, 0, 1'b1);
      idle(2, 1'b1);
      checkOutput("t2_err_count", err_count, 1);
      checkOutput("t2_valid", pkt_valid, 0);
      checkpoint("t2");
    end

    // Timeout after a partial packet, then a normal packet.
    send_byte(SYNC, 0, 1'b1);
    send_byte(8'h11, 0, 1'b1);
    idle(T + 3, 1'b1);
    checkOutput("t3_err_count", err_count, 1 + CSUM_EN);
    send_packet(32'hDDCCBBAA, 1'b0, 2, 1'b1, 1'b1);
    checkpoint("t3");
    // Byte exactly on the deadline is accepted; one cycle later times out.
    send_packet(32'h0F0E0D0C, 1'b0, T, 1'b1, 1'b1);
    checkpoint("t3_edge_ok");
    send_byte(SYNC, 0, 1'b1);
    send_byte(8'h11, T + 1, 1'b1);
    checkpoint("t3_edge_tmo");

    // Overrun with ready low, then acceptance in the completion cycle.
    send_packet(32'h01010101, 1'b0, 0, 1'b0, 1'b0);
    send_packet(32'h02020202, 1'b0, 0, 1'b0, 1'b0);
    idle(2, 1'b0);
    checkOutput("t4_held_data", pkt_data, 32'h01010101);
    idle(1, 1'b1);
    send_packet(32'h03030303, 1'b0, 0, 1'b0, 1'b0);
    send_packet(32'h04040404, 1'b0, 0, 1'b0, 1'b1);
    idle(2, 1'b0);
    checkOutput("t4_new_data", pkt_data, 32'h04040404);
    checkpoint("t4");

    // Leading junk and a sync value inside the payload.
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'hFF, 0, 1'b0);
    send_packet(32'h030201A5, 1'b0, 0, 1'b0, 1'b0);
    idle(2, 1'b0);
    checkOutput("t5_data", pkt_data, 32'h030201A5);
    checkpoint("t5");

    // Reset mid-packet, then a clean packet.
    send_byte(SYNC, 0, 1'b1);
    send_byte(8'h11, 0, 1'b1);
    do_reset();
    check_reset_outputs("t6_reset");
    send_packet(32'h87654321, 1'b0, 1, 1'b1, 1'b1);
    checkpoint("t6");

    // Error counter saturation.
    for (int k = 0; k < 300; k++) begin
      if (CSUM_EN == 1) send_packet(32'($urandom), 1'b1, 0, 1'b1, 1'b1);
      else              send_packet(32'($urandom), 1'b0, 0, 1'b0, 1'b0);
    end
    checkpoint("t6_sat");
    checkOutput("t6_sat_value", err_count, 8'hFF);

    // Randomized traffic.
    do_reset();
    for (int k = 0; k < 80; k++) begin
      rdy = 1'($urandom_range(0, 1));
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) send_byte(8'($urandom), 0, rdy);
      case ($urandom_range(0, 9))
        0:       gap = T;
        1:       gap = T + 1;
        default: gap = int'($urandom_range(0, 3));
      endcase
      send_packet(32'($urandom), ($urandom_range(0, 4) == 0), gap, rdy,
                  1'($urandom_range(0, 1)));
    end
    checkpoint("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
